// File: rtl/agc_epcs_pkg.sv
// Shared constants, frame geometry and FSM state type for the EPCS rope reader.
// Optional build macro: EPCS_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy bits.
package agc_epcs_pkg;

  localparam logic [7:0] EPCS_CMD_READ      = 8'h03;
  localparam logic [7:0] EPCS_CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 16;

`ifdef EPCS_FAST_READ_EN
  localparam logic [7:0] EPCS_CMD = EPCS_CMD_FAST_READ;
  localparam int         PAD_BITS = DUMMY_BITS;
`else
  localparam logic [7:0] EPCS_CMD = EPCS_CMD_READ;
  localparam int         PAD_BITS = 0;
`endif

  localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + PAD_BITS + DATA_BITS;
  localparam int DATA_START = FRAME_BITS - DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    GAP
  } epcs_state_t;

endpackage

// File: rtl/epcs_sclk_div.sv
// EPCS serial clock generator: DCLK starts low, each half-period lasts CLK_DIV cycles.
// rise/fall are single-cycle strobes marking the clock edge where DCLK toggles.
module epcs_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic dclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));
  assign rise = en & last & ~dclk;
  assign fall = en & last & dclk;

  // Disabling forces DCLK low, so a high phase can never start outside a transfer
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt  <= '0;
      dclk <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      dclk <= ~dclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/epcs_rope_reader.sv
// Fetches one 16-bit rope word from EPCS flash per request (READ, or FAST READ when
// EPCS_FAST_READ_EN is defined) and enforces chip-select high time between accesses.
module epcs_rope_reader
  import agc_epcs_pkg::*;
#(
  parameter int          CLK_DIV   = 4,
  parameter logic [23:0] BASE_ADDR = 24'h100000,
  parameter int          CS_GAP    = 8
) (
  input  logic        SYS_CLK,
  input  logic        SIM_RST_n,
  input  logic        REQ,
  input  logic [15:0] REQ_ADDR,
  output logic        BUSY,
  output logic [15:0] RDATA,
  output logic        RVALID,
  input  logic        EPCS_DATA,
  output logic        EPCS_CSN,
  output logic        EPCS_DCLK,
  output logic        EPCS_ASDI
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
  localparam int SW = CMD_BITS + ADDR_BITS;

  epcs_state_t    state, state_nxt;
  logic [GW-1:0]  gap_cnt;
  logic [5:0]     hi_cnt;
  logic [SW-1:0]  sh_out;
  logic [15:0]    sh_in;
  logic [23:0]    byte_addr;
  logic           accept;
  logic           dclk, rise, fall;
  logic           last_fall, data_fall;

  assign byte_addr = BASE_ADDR + {7'd0, REQ_ADDR, 1'b0};
  assign accept    = (state == IDLE) && REQ;
  // hi_cnt counts high phases begun, so at a fall it equals the finishing bit's index + 1
  assign last_fall = fall && (hi_cnt == 6'(FRAME_BITS));
  assign data_fall = fall && (hi_cnt > 6'(DATA_START));

  epcs_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk  (SYS_CLK),
    .rst_n(SIM_RST_n),
    .en   (state == SHIFT),
    .dclk (dclk),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge SYS_CLK) begin
    if (!SIM_RST_n) state <= GAP;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (REQ) state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = DONE;
      DONE:    state_nxt = GAP;
      GAP:     if (gap_cnt == GW'(CS_GAP - 1)) state_nxt = IDLE;
      default: state_nxt = GAP;
    endcase
  end

  always_comb begin
    BUSY      = (state != IDLE);
    EPCS_CSN  = (state != SHIFT);
    RVALID    = (state == DONE);
    EPCS_DCLK = dclk;
    EPCS_ASDI = sh_out[SW-1];
  end

  // Serialiser: new ASDI bit is presented as each bit's low phase begins
  always_ff @(posedge SYS_CLK) begin
    if (!SIM_RST_n) begin
      gap_cnt <= '0;
      hi_cnt  <= '0;
      sh_out  <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        sh_out <= {EPCS_CMD, byte_addr};
        hi_cnt <= '0;
      end else begin
        if (rise) hi_cnt <= hi_cnt + 1'b1;
        if (fall) sh_out <= {sh_out[SW-2:0], 1'b0};
      end
    end
  end

  // Deserialiser: flash data sampled as DCLK drops, high byte first
  always_ff @(posedge SYS_CLK) begin
    if (data_fall) sh_in <= {sh_in[14:0], EPCS_DATA};
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SIM_RST_n)     RDATA <= '0;
    else if (last_fall) RDATA <= {sh_in[14:0], EPCS_DATA};
  end

endmodule

// File: tb/tb_epcs_rope_reader.sv
// Directed bench: three readers with different BASE_ADDR share one request bus and one
// flash model; ASDI frames are captured per reader and compared to hand-computed values.
module tb_epcs_rope_reader;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
`ifdef EPCS_FAST_READ_EN
  localparam int         FRAME = 56;
  localparam logic [7:0] CMD   = 8'h0B;
`else
  localparam int         FRAME = 48;
  localparam logic [7:0] CMD   = 8'h03;
`endif
  localparam int DSTART = FRAME - 16;
  localparam int LAT    = 1 + 2 * CLK_DIV * FRAME;

  typedef struct {
    logic [15:0] req_addr;
    logic [15:0] word;
    logic [23:0] a0;
    logic [23:0] a1;
    logic [23:0] a2;
  } vec_t;

  logic        SYS_CLK    = 1'b0;
  logic        SIM_RST_n  = 1'b0;
  logic        REQ        = 1'b0;
  logic [15:0] REQ_ADDR   = 16'h0;
  logic        flash_do   = 1'b0;
  logic [15:0] flash_word = 16'h0;

  wire  [2:0]  busy, rvalid, csn, dclk, asdi;
  wire  [15:0] rdata   [3];
  wire  [63:0] frame_a [3];
  wire  [31:0] nbits_a [3];

  int checks = 0;
  int errors = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    epcs_rope_reader #(
      .CLK_DIV  (CLK_DIV),
      .BASE_ADDR(gi == 0 ? 24'h000000 : (gi == 1 ? 24'h100000 : 24'hFFFFFE)),
      .CS_GAP   (CS_GAP)
    ) u_dut (
      .SYS_CLK  (SYS_CLK),
      .SIM_RST_n(SIM_RST_n),
      .REQ      (REQ),
      .REQ_ADDR (REQ_ADDR),
      .BUSY     (busy[gi]),
      .RDATA    (rdata[gi]),
      .RVALID   (rvalid[gi]),
      .EPCS_DATA(flash_do),
      .EPCS_CSN (csn[gi]),
      .EPCS_DCLK(dclk[gi]),
      .EPCS_ASDI(asdi[gi])
    );

    logic        dclk_q = 1'b0;
    logic        csn_q  = 1'b1;
    logic [63:0] frame  = 64'h0;
    logic [31:0] nbits  = 32'h0;

    always @(negedge SYS_CLK) begin
      dclk_q <= dclk[gi];
      csn_q  <= csn[gi];
      if (!csn[gi] && csn_q) begin
        frame <= 64'h0;
        nbits <= 32'h0;
      end else if (!csn[gi] && dclk[gi] && !dclk_q) begin
        frame <= {frame[62:0], asdi[gi]};
        nbits <= nbits + 1;
      end
    end

    assign frame_a[gi] = frame;
    assign nbits_a[gi] = nbits;
  end

  // Flash model: presents each data bit as DCLK rises; also watches DCLK phase integrity
  logic d0_q      = 1'b0;
  int   fbit      = 0;
  int   hi_len    = 0;
  logic glitch    = 1'b0;
  logic bad_phase = 1'b0;

  always @(negedge SYS_CLK) begin
    d0_q <= dclk[0];
    if (csn[0]) fbit <= 0;
    else if (dclk[0] && !d0_q) begin
      if (fbit >= DSTART && fbit < FRAME) flash_do <= flash_word[4'(15 - (fbit - DSTART))];
      fbit <= fbit + 1;
    end
    if (dclk[0] && csn[0]) glitch <= 1'b1;
    if (dclk[0]) hi_len <= hi_len + 1;
    else if (d0_q) begin
      if (hi_len != CLK_DIV) bad_phase <= 1'b1;
      hi_len <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy[0] && n < 2000) begin
      @(negedge SYS_CLK);
      n++;
    end
    if (busy[0]) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Releases reset at a negedge and counts BUSY-high cycles including the current one
  task automatic release_count(output int n);
    SIM_RST_n = 1'b1;
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge SYS_CLK);
      if (busy[0]) n++;
      else break;
    end
  endtask

  task automatic do_txn(input logic [15:0] a, input logic [15:0] w, input int req_at,
                        input int abort_at, output int lat, output int low, output int rv_wide);
    flash_word = w;
    wait_idle();
    REQ = 1'b1;
    REQ_ADDR = a;
    @(posedge SYS_CLK);
    lat = 0;
    low = 0;
    rv_wide = 0;
    for (int j = 0; j < 3000; j++) begin
      @(negedge SYS_CLK);
      if (j == 0) begin REQ = 1'b0; REQ_ADDR = 16'hDEAD; end
      if (j == req_at - 1) begin REQ = 1'b1; REQ_ADDR = ~a; end
      if (j == req_at) begin REQ = 1'b0; REQ_ADDR = 16'hDEAD; end
      if (j == abort_at) break;
      if (!csn[0]) low++;
      if (rvalid[0]) begin
        lat = j + 1;
        @(negedge SYS_CLK);
        rv_wide = int'(rvalid[0]);
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs [6];
    int lat, low, rvw, n, pulses, lows, r1, r2, hi, phase;
    logic [63:0] mask;

    vecs[0] = '{16'h0000, 16'h1234, 24'h000000, 24'h100000, 24'hFFFFFE};
    vecs[1] = '{16'h8001, 16'hABCD, 24'h010002, 24'h110002, 24'h010000};
    vecs[2] = '{16'h0001, 16'h7FFF, 24'h000002, 24'h100002, 24'h000000};
    vecs[3] = '{16'hFFFF, 16'h8001, 24'h01FFFE, 24'h11FFFE, 24'h01FFFC};
    vecs[4] = '{16'h1234, 16'h0000, 24'h002468, 24'h102468, 24'h002466};
    vecs[5] = '{16'h7FFE, 16'hFFFF, 24'h00FFFC, 24'h10FFFC, 24'h00FFFA};
    mask = (64'd1 << (FRAME - 32)) - 64'd1;

    SIM_RST_n = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    check("rst_csn", 64'(csn[0]), 64'd1);
    check("rst_dclk", 64'(dclk[0]), 64'd0);
    check("rst_asdi", 64'(asdi[0]), 64'd0);
    check("rst_rdata", 64'(rdata[0]), 64'd0);
    check("rst_rvalid", 64'(rvalid[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd1);
    release_count(n);
    check("rst_gap_busy", 64'(n), 64'(CS_GAP));

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].req_addr, vecs[i].word, -1, -1, lat, low, rvw);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("v%0d_csn_low", i), 64'(low), 64'(LAT - 1));
      check($sformatf("v%0d_rvalid_width", i), 64'(rvw), 64'd0);
      check($sformatf("v%0d_dclk_count", i), 64'(nbits_a[0]), 64'(FRAME));
      check($sformatf("v%0d_cmd", i), 64'(8'(frame_a[0] >> (FRAME - 8))), 64'(CMD));
      check($sformatf("v%0d_addr0", i), 64'(24'(frame_a[0] >> (FRAME - 32))), 64'(vecs[i].a0));
      check($sformatf("v%0d_addr1", i), 64'(24'(frame_a[1] >> (FRAME - 32))), 64'(vecs[i].a1));
      check($sformatf("v%0d_addr2", i), 64'(24'(frame_a[2] >> (FRAME - 32))), 64'(vecs[i].a2));
      check($sformatf("v%0d_asdi_tail_zero", i), frame_a[0] & mask, 64'd0);
      for (int k = 0; k < 3; k++)
        check($sformatf("v%0d_rdata%0d", i, k), 64'(rdata[k]), 64'(vecs[i].word));
    end

    // Request during a transfer must be dropped, not queued
    do_txn(16'h0042, 16'h5A5A, 50, -1, lat, low, rvw);
    check("ign_latency", 64'(lat), 64'(LAT));
    check("ign_addr", 64'(24'(frame_a[0] >> (FRAME - 32))), 64'h000084);
    check("ign_rdata", 64'(rdata[0]), 64'h5A5A);
    pulses = 0;
    lows = 0;
    for (int j = 0; j < 500; j++) begin
      @(negedge SYS_CLK);
      if (rvalid[0]) pulses++;
      if (!csn[0]) lows++;
    end
    check("ign_extra_rvalid", 64'(pulses), 64'd0);
    check("ign_extra_csn_low", 64'(lows), 64'd0);

    // REQ held high: CSN high spans DONE, CS_GAP GAP cycles and the accepting IDLE cycle
    flash_word = 16'hC3A5;
    wait_idle();
    REQ = 1'b1;
    REQ_ADDR = 16'h0010;
    r1 = -1;
    r2 = -1;
    hi = 0;
    phase = 0;
    for (int j = 0; j < 2000; j++) begin
      @(negedge SYS_CLK);
      if (rvalid[0]) begin
        if (r1 < 0) r1 = j;
        else begin r2 = j; break; end
      end
      if (r1 >= 0 && phase == 0) begin
        if (csn[0]) hi++;
        else begin phase = 1; REQ = 1'b0; end
      end
    end
    REQ = 1'b0;
    check("b2b_csn_high", 64'(hi), 64'(CS_GAP + 2));
    check("b2b_rvalid_spacing", 64'(r2 - r1), 64'(2 * CLK_DIV * FRAME + CS_GAP + 2));
    check("b2b_rdata", 64'(rdata[0]), 64'hC3A5);

    // Reset in the middle of the address phase
    do_txn(16'h0100, 16'h0F0F, -1, 120, lat, low, rvw);
    SIM_RST_n = 1'b0;
    @(negedge SYS_CLK);
    check("mid_rst_csn", 64'(csn[0]), 64'd1);
    check("mid_rst_dclk", 64'(dclk[0]), 64'd0);
    check("mid_rst_rvalid", 64'(rvalid[0]), 64'd0);
    check("mid_rst_rdata", 64'(rdata[0]), 64'd0);
    check("mid_rst_busy", 64'(busy[0]), 64'd1);
    release_count(n);
    check("mid_rst_gap_busy", 64'(n), 64'(CS_GAP));
    pulses = 0;
    for (int j = 0; j < 500; j++) begin
      @(negedge SYS_CLK);
      if (rvalid[0]) pulses++;
    end
    check("mid_rst_no_rvalid", 64'(pulses), 64'd0);

    check("dclk_high_while_csn_high", 64'(glitch), 64'd0);
    check("dclk_high_phase_len", 64'(bad_phase), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
